// File: rtl/multicycle_control_fsm_pkg.sv
// Shared definitions for the multi-cycle control unit,
// ALU-control decoder and datapath.
package multicycle_control_fsm_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_NORI  = 6'b001101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_NORI  = 2'b11;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] RD_RT  = 2'b00;
  localparam logic [1:0] RD_RD  = 2'b01;
  localparam logic [1:0] RD_R31 = 2'b10;

  localparam logic [1:0] ASB_B     = 2'b00;
  localparam logic [1:0] ASB_FOUR  = 2'b01;
  localparam logic [1:0] ASB_IMM   = 2'b10;
  localparam logic [1:0] ASB_IMMSH = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_A      = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEXEC = 4'd6,
    S_RTWB   = 4'd7,
    S_BEQ    = 4'd8,
    S_ITEXEC = 4'd9,
    S_ITWB   = 4'd10,
    S_BALRZ  = 4'd11
  } state_t;

  typedef struct packed {
    logic [1:0] aluop;
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic [1:0] memtoreg;
    logic [1:0] regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsource;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the control FSM and the datapath:
// opcode/status inputs and all mux selects and write enables.
interface multicycle_control_fsm_if;
  logic [5:0] op;
  logic       balrz;
  logic       zflag;
  logic [1:0] aluop;
  logic       pcwrite;
  logic       pcwritecond;
  logic       iord;
  logic       memread;
  logic       memwrite;
  logic       irwrite;
  logic [1:0] memtoreg;
  logic [1:0] regdst;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsource;
  logic       instr_done;
  logic       illegal_op;

  modport master (
    input  op, balrz, zflag,
    output aluop, pcwrite, pcwritecond, iord,
    output memread, memwrite, irwrite,
    output memtoreg, regdst, regwrite,
    output alusrca, alusrcb, pcsource,
    output instr_done, illegal_op
  );

  modport slave (
    output op, balrz, zflag,
    input  aluop, pcwrite, pcwritecond, iord,
    input  memread, memwrite, irwrite,
    input  memtoreg, regdst, regwrite,
    input  alusrca, alusrcb, pcsource,
    input  instr_done, illegal_op
  );
endinterface

// File: rtl/multicycle_control_fsm_ctrl_outdec.sv
// Moore output decoder: state (+zflag in BALRZ) to control vector.
module ctrl_outdec
  import multicycle_control_fsm_pkg::*;
(
  input  state_t i_state,
  input  logic   i_zflag,
  output ctrl_t  o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    unique case (i_state)
      S_FETCH: begin
        o_ctrl.memread = 1'b1;
        o_ctrl.irwrite = 1'b1;
        o_ctrl.alusrcb = ASB_FOUR;
        o_ctrl.aluop   = ALUOP_ADD;
        o_ctrl.pcwrite = 1'b1;
      end
      S_DECODE: begin
        o_ctrl.alusrcb = ASB_IMMSH;
        o_ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMADR: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = ASB_IMM;
        o_ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMRD: begin
        o_ctrl.memread = 1'b1;
        o_ctrl.iord    = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.regwrite   = 1'b1;
        o_ctrl.memtoreg   = M2R_MDR;
        o_ctrl.regdst     = RD_RT;
        o_ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        o_ctrl.memwrite   = 1'b1;
        o_ctrl.iord       = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_RTEXEC: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = ASB_B;
        o_ctrl.aluop   = ALUOP_RTYPE;
      end
      S_RTWB: begin
        o_ctrl.regwrite   = 1'b1;
        o_ctrl.regdst     = RD_RD;
        o_ctrl.memtoreg   = M2R_ALUOUT;
        o_ctrl.instr_done = 1'b1;
      end
      S_BEQ: begin
        o_ctrl.alusrca     = 1'b1;
        o_ctrl.aluop       = ALUOP_SUB;
        o_ctrl.pcwritecond = 1'b1;
        o_ctrl.pcsource    = PCS_ALUOUT;
        o_ctrl.instr_done  = 1'b1;
      end
      S_ITEXEC: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = ASB_IMM;
        o_ctrl.aluop   = ALUOP_NORI;
      end
      S_ITWB: begin
        o_ctrl.regwrite   = 1'b1;
        o_ctrl.regdst     = RD_RT;
        o_ctrl.memtoreg   = M2R_ALUOUT;
        o_ctrl.instr_done = 1'b1;
      end
      S_BALRZ: begin
        o_ctrl.instr_done = 1'b1;
        // link PC+4 into $31 on the same edge the PC loads A
        if (i_zflag) begin
          o_ctrl.pcwrite  = 1'b1;
          o_ctrl.pcsource = PCS_A;
          o_ctrl.regwrite = 1'b1;
          o_ctrl.regdst   = RD_R31;
          o_ctrl.memtoreg = M2R_PC;
        end
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle main control FSM: state register, next-state
// logic and reset gating of the decoded control vector.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  multicycle_control_fsm_if.master bus
);

  state_t r_state;
  state_t w_next;
  logic   w_illegal;
  ctrl_t  w_dec;
  ctrl_t  w_out;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = S_FETCH;
    w_illegal = 1'b0;
    unique case (r_state)
      S_FETCH: w_next = S_DECODE;
      S_DECODE: begin
        unique case (bus.op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_RTEXEC;
          OP_BEQ:       w_next = S_BEQ;
          OP_NORI:      w_next = S_ITEXEC;
          default: begin
            w_next    = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: w_next = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = S_MEMWB;
      S_RTEXEC: w_next = bus.balrz ? S_BALRZ : S_RTWB;
      S_ITEXEC: w_next = S_ITWB;
      default:  w_next = S_FETCH;
    endcase
  end

  ctrl_outdec u_outdec (
    .i_state (r_state),
    .i_zflag (bus.zflag),
    .o_ctrl  (w_dec)
  );

  // reset masks everything so no write enable fires mid-abort
  assign w_out = reset ? '0 : w_dec;

  assign bus.aluop       = w_out.aluop;
  assign bus.pcwrite     = w_out.pcwrite;
  assign bus.pcwritecond = w_out.pcwritecond;
  assign bus.iord        = w_out.iord;
  assign bus.memread     = w_out.memread;
  assign bus.memwrite    = w_out.memwrite;
  assign bus.irwrite     = w_out.irwrite;
  assign bus.memtoreg    = w_out.memtoreg;
  assign bus.regdst      = w_out.regdst;
  assign bus.regwrite    = w_out.regwrite;
  assign bus.alusrca     = w_out.alusrca;
  assign bus.alusrcb     = w_out.alusrcb;
  assign bus.pcsource    = w_out.pcsource;
  assign bus.instr_done  = w_out.instr_done;
  assign bus.illegal_op  = w_illegal & ~reset;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench: instruction vector table plus
// hand sequences, expected vectors scoreboarded per cycle.
module tb_multicycle_control_fsm;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_control_fsm_if bus();

  multicycle_control_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        balrz;
    logic        zflag;
    logic [19:0] exp;
    string       name;
  } vec_t;

  typedef struct {
    logic [19:0] exp;
    string       name;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_cnt = 0;

  logic [19:0] ZERO, FETCH, DECODE, ILLDEC, MEMADR, MEMRD, MEMWB,
               MEMWR, RTEXEC, RTWB, BEQ, ITEXEC, ITWB, BALZ1, BALZ0;

  function automatic logic [19:0] mk(
    input logic [1:0] aluop, input logic pcw, input logic pcwc,
    input logic iord, input logic mr, input logic mw, input logic irw,
    input logic [1:0] m2r, input logic [1:0] rd, input logic rw,
    input logic asa, input logic [1:0] asb, input logic [1:0] pcs,
    input logic done, input logic ill);
    return {aluop, pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw,
            asa, asb, pcs, done, ill};
  endfunction

  function automatic logic [19:0] dut_vec();
    return {bus.aluop, bus.pcwrite, bus.pcwritecond, bus.iord,
            bus.memread, bus.memwrite, bus.irwrite, bus.memtoreg,
            bus.regdst, bus.regwrite, bus.alusrca, bus.alusrcb,
            bus.pcsource, bus.instr_done, bus.illegal_op};
  endfunction

  task automatic chk(input string nm, input logic [19:0] got,
                     input logic [19:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%05h want=%05h", nm, got, want);
    end
  endtask

  task automatic add(input logic rst, input logic [5:0] op,
                     input logic bz, input logic zf,
                     input logic [19:0] exp, input string nm);
    vec_t v;
    v.rst = rst; v.op = op; v.balrz = bz; v.zflag = zf;
    v.exp = exp; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    sb_t e;
    logic [19:0] g;
    @(posedge clk);
    #1;
    reset     = v.rst;
    bus.op    = v.op;
    bus.balrz = v.balrz;
    bus.zflag = v.zflag;
    e.exp = v.exp; e.name = v.name;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    g = dut_vec();
    chk(e.name, g, e.exp);
    chk({e.name, "_pcx"}, {19'd0, bus.pcwrite & bus.pcwritecond}, 20'd0);
    chk({e.name, "_memx"}, {19'd0, bus.memread & bus.memwrite}, 20'd0);
    if (bus.instr_done) done_cnt++;
  endtask

  task automatic step(input logic rst, input logic [5:0] op,
                      input logic bz, input logic zf,
                      input logic [19:0] exp, input string nm);
    vec_t v;
    v.rst = rst; v.op = op; v.balrz = bz; v.zflag = zf;
    v.exp = exp; v.name = nm;
    apply(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    reset = 1'b1; bus.op = '0; bus.balrz = 1'b0; bus.zflag = 1'b0;

    ZERO   = '0;
    FETCH  = mk(2'b00,1,0,0,1,0,1,2'b00,2'b00,0,0,2'b01,2'b00,0,0);
    DECODE = mk(2'b00,0,0,0,0,0,0,2'b00,2'b00,0,0,2'b11,2'b00,0,0);
    ILLDEC = mk(2'b00,0,0,0,0,0,0,2'b00,2'b00,0,0,2'b11,2'b00,0,1);
    MEMADR = mk(2'b00,0,0,0,0,0,0,2'b00,2'b00,0,1,2'b10,2'b00,0,0);
    MEMRD  = mk(2'b00,0,0,1,1,0,0,2'b00,2'b00,0,0,2'b00,2'b00,0,0);
    MEMWB  = mk(2'b00,0,0,0,0,0,0,2'b01,2'b00,1,0,2'b00,2'b00,1,0);
    MEMWR  = mk(2'b00,0,0,1,0,1,0,2'b00,2'b00,0,0,2'b00,2'b00,1,0);
    RTEXEC = mk(2'b10,0,0,0,0,0,0,2'b00,2'b00,0,1,2'b00,2'b00,0,0);
    RTWB   = mk(2'b00,0,0,0,0,0,0,2'b00,2'b01,1,0,2'b00,2'b00,1,0);
    BEQ    = mk(2'b01,0,1,0,0,0,0,2'b00,2'b00,0,1,2'b00,2'b01,1,0);
    ITEXEC = mk(2'b11,0,0,0,0,0,0,2'b00,2'b00,0,1,2'b10,2'b00,0,0);
    ITWB   = mk(2'b00,0,0,0,0,0,0,2'b00,2'b00,1,0,2'b00,2'b00,1,0);
    BALZ1  = mk(2'b00,1,0,0,0,0,0,2'b10,2'b10,1,0,2'b00,2'b10,1,0);
    BALZ0  = mk(2'b00,0,0,0,0,0,0,2'b00,2'b00,0,0,2'b00,2'b00,1,0);

    add(1, 6'h00, 0, 0, ZERO,   "rst0");
    add(1, 6'h00, 0, 0, ZERO,   "rst1");
    add(0, 6'h00, 0, 0, FETCH,  "r0_fetch");
    add(0, 6'h00, 0, 0, DECODE, "r0_decode");
    add(1, 6'h00, 0, 0, ZERO,   "rst_mid_rtexec");
    add(1, 6'h00, 0, 0, ZERO,   "rst_mid2");
    add(1, 6'h00, 0, 0, ZERO,   "rst_mid3");
    add(0, 6'h00, 0, 0, FETCH,  "rt_fetch");
    add(0, 6'h00, 0, 0, DECODE, "rt_decode");
    add(0, 6'h00, 0, 0, RTEXEC, "rt_exec");
    add(0, 6'h00, 0, 0, RTWB,   "rt_wb");
    add(0, 6'h23, 0, 0, FETCH,  "lw_fetch");
    add(0, 6'h23, 0, 0, DECODE, "lw_decode");
    add(0, 6'h23, 0, 0, MEMADR, "lw_memadr");
    add(0, 6'h23, 0, 0, MEMRD,  "lw_memrd");
    add(0, 6'h23, 0, 0, MEMWB,  "lw_memwb");
    add(0, 6'h2b, 0, 0, FETCH,  "sw_fetch");
    add(0, 6'h2b, 0, 0, DECODE, "sw_decode");
    add(0, 6'h2b, 0, 0, MEMADR, "sw_memadr");
    add(0, 6'h2b, 0, 0, MEMWR,  "sw_memwr");
    add(0, 6'h00, 1, 1, FETCH,  "bz1_fetch");
    add(0, 6'h00, 1, 1, DECODE, "bz1_decode");
    add(0, 6'h00, 1, 1, RTEXEC, "bz1_exec");
    add(0, 6'h00, 1, 1, BALZ1,  "bz1_balrz");
    add(0, 6'h00, 1, 0, FETCH,  "bz0_fetch");
    add(0, 6'h00, 1, 0, DECODE, "bz0_decode");
    add(0, 6'h00, 1, 0, RTEXEC, "bz0_exec");
    add(0, 6'h00, 1, 0, BALZ0,  "bz0_balrz");
    add(0, 6'h04, 0, 0, FETCH,  "beq_fetch");
    add(0, 6'h04, 0, 0, DECODE, "beq_decode");
    add(0, 6'h04, 0, 0, BEQ,    "beq_exec");
    add(0, 6'h0d, 0, 0, FETCH,  "nori_fetch");
    add(0, 6'h0d, 0, 0, DECODE, "nori_decode");
    add(0, 6'h0d, 0, 0, ITEXEC, "nori_exec");
    add(0, 6'h0d, 0, 0, ITWB,   "nori_wb");
    add(0, 6'h3f, 0, 0, FETCH,  "ill_fetch");
    add(0, 6'h3f, 0, 0, ILLDEC, "ill_decode");
    add(0, 6'h3f, 0, 0, FETCH,  "ill_refetch");
    add(0, 6'h3f, 0, 0, ILLDEC, "ill_decode2");

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // instr_done must pulse exactly once across a load
    d0 = done_cnt;
    step(0, 6'h23, 0, 0, FETCH,  "lw2_fetch");
    step(0, 6'h23, 0, 0, DECODE, "lw2_decode");
    step(0, 6'h23, 0, 0, MEMADR, "lw2_memadr");
    step(0, 6'h23, 0, 0, MEMRD,  "lw2_memrd");
    step(0, 6'h23, 0, 0, MEMWB,  "lw2_memwb");
    chk("lw2_done_once", done_cnt - d0, 20'd1);

    // op re-sampled in MEMADR; balrz ignored outside RTEXEC
    step(0, 6'h23, 1, 1, FETCH,  "rs_fetch");
    step(0, 6'h23, 1, 1, DECODE, "rs_decode");
    step(0, 6'h2b, 1, 1, MEMADR, "rs_memadr");
    step(0, 6'h2b, 1, 1, MEMWR,  "rs_memwr");

    // zflag flips in BALRZ are seen combinationally
    step(0, 6'h00, 1, 0, FETCH,  "bzf_fetch");
    step(0, 6'h00, 1, 0, DECODE, "bzf_decode");
    step(0, 6'h00, 1, 0, RTEXEC, "bzf_exec");
    step(0, 6'h00, 0, 1, BALZ1,  "bzf_balrz");

    // reset during DECODE of an illegal op suppresses illegal_op
    step(0, 6'h3f, 0, 0, FETCH,  "ri_fetch");
    step(1, 6'h3f, 0, 0, ZERO,   "ri_rst");
    step(0, 6'h3f, 0, 0, FETCH,  "ri_fetch2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
